// File: rtl/instr_fetch_mem.sv
// rtl/instr_fetch_mem.sv - instruction memory with zero-fill on reset, 1-cycle fetch port and word load port
module instr_fetch_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_BYTES  = 1024,
    parameter int CELL_WIDTH = 8,
    parameter int INST_BYTES = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fetch_req,
    input  logic [ADDR_WIDTH-1:0]            fetch_addr,
    input  logic                             fetch_stall,
    output logic [CELL_WIDTH*INST_BYTES-1:0] inst,
    output logic                             inst_valid,
    output logic                             fault_misalign,
    output logic                             fault_range,
    input  logic                             ld_we,
    input  logic [ADDR_WIDTH-1:0]            ld_addr,
    input  logic [CELL_WIDTH*INST_BYTES-1:0] ld_data,
    output logic                             ld_ack,
    output logic                             ready
);
    localparam int WORDS  = MEM_BYTES / INST_BYTES;
    localparam int OFF    = $clog2(INST_BYTES);
    localparam int IDX_W  = $clog2(WORDS);
    localparam int WORD_W = CELL_WIDTH * INST_BYTES;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [IDX_W-1:0]  r_cnt;
    // Cells are packed little-endian into words: cell A lands in bits [CELL_WIDTH-1:0].
    // Loads always write whole aligned words, so word granularity storage suffices.
    logic [WORD_W-1:0] r_mem [WORDS];

    logic [WORD_W-1:0] r_inst;
    logic              r_inst_valid;
    logic              r_fault_misalign;
    logic              r_fault_range;
    logic              r_ld_ack;

    logic             w_clear_last;
    logic             w_f_mis;
    logic             w_f_rng;
    logic             w_l_mis;
    logic             w_l_rng;
    logic             w_ld_ok;
    logic [IDX_W-1:0] w_f_idx;
    logic [IDX_W-1:0] w_l_idx;

    assign w_clear_last = (r_cnt == IDX_W'(WORDS - 1));
    assign w_f_mis      = (fetch_addr & ADDR_WIDTH'(INST_BYTES - 1)) != '0;
    assign w_f_rng      = fetch_addr >= ADDR_WIDTH'(MEM_BYTES);
    assign w_l_mis      = (ld_addr & ADDR_WIDTH'(INST_BYTES - 1)) != '0;
    assign w_l_rng      = ld_addr >= ADDR_WIDTH'(MEM_BYTES);
    assign w_f_idx      = fetch_addr[OFF +: IDX_W];
    assign w_l_idx      = ld_addr[OFF +: IDX_W];
    assign w_ld_ok      = (r_state == S_RUN) && ld_we && !w_l_mis && !w_l_rng;

    // State register: reset always restarts the zero-fill sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: leave CLEAR once the last word has been zeroed.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CLEAR: if (w_clear_last) w_next = S_RUN;
            S_RUN:   w_next = S_RUN;
            default: w_next = S_CLEAR;
        endcase
    end

    // Zero-fill word counter, advanced once per CLEAR cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Single write port shared by the zero-fill sweep and program loads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_cnt] <= '0;
            end else if (w_ld_ok) begin
                r_mem[w_l_idx] <= ld_data;
            end
        end
    end

    // Output stage: registered read (old data on same-cycle write), frozen by stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst           <= '0;
            r_inst_valid     <= 1'b0;
            r_fault_misalign <= 1'b0;
            r_fault_range    <= 1'b0;
            r_ld_ack         <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            r_inst_valid <= 1'b0;
            r_ld_ack     <= 1'b0;
        end else begin
            r_ld_ack <= w_ld_ok;
            if (!fetch_stall) begin
                r_inst_valid     <= fetch_req;
                r_fault_misalign <= fetch_req && w_f_mis;
                r_fault_range    <= fetch_req && w_f_rng;
                r_inst           <= (fetch_req && !w_f_mis && !w_f_rng) ? r_mem[w_f_idx] : '0;
            end
        end
    end

    assign inst           = r_inst;
    assign inst_valid     = r_inst_valid;
    assign fault_misalign = r_fault_misalign;
    assign fault_range    = r_fault_range;
    assign ld_ack         = r_ld_ack;
    assign ready          = (r_state == S_RUN);
endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb/tb_instr_fetch_mem.sv - randomized and directed checks of instr_fetch_mem against a byte-level model
module tb_instr_fetch_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_stall;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fault_misalign;
    logic        fault_range;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_ack;
    logic        ready;

    always #5 clk = ~clk;

    instr_fetch_mem dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_stall    (fetch_stall),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .fault_misalign (fault_misalign),
        .fault_range    (fault_range),
        .ld_we          (ld_we),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .ld_ack         (ld_ack),
        .ready          (ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  m_mem [1024];
    int          m_clear = 256;
    logic [31:0] e_inst  = '0;
    logic        e_valid = 1'b0;
    logic        e_mis   = 1'b0;
    logic        e_rng   = 1'b0;
    logic        e_ack   = 1'b0;
    logic        e_ready = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_word(input logic [31:0] a);
        return {m_mem[a + 3], m_mem[a + 2], m_mem[a + 1], m_mem[a]};
    endfunction

    // Advance the model by one clock from the current inputs, clock the DUT, compare everything.
    task automatic step();
        logic ld_ok;
        if (rst) begin
            m_clear = 256;
            e_inst = '0; e_valid = 0; e_mis = 0; e_rng = 0; e_ack = 0;
            foreach (m_mem[i]) m_mem[i] = 8'h00;
        end else if (m_clear > 0) begin
            m_clear--;
            e_valid = 0;
            e_ack   = 0;
        end else begin
            ld_ok = ld_we && (ld_addr % 4 == 0) && (ld_addr < 1024);
            e_ack = ld_ok;
            if (!fetch_stall) begin
                e_valid = fetch_req;
                e_mis   = fetch_req && (fetch_addr % 4 != 0);
                e_rng   = fetch_req && (fetch_addr >= 1024);
                e_inst  = (fetch_req && !e_mis && !e_rng) ? m_word(fetch_addr) : 32'h0;
            end
            if (ld_ok) begin
                for (int i = 0; i < 4; i++) m_mem[ld_addr + i] = ld_data[8*i +: 8];
            end
        end
        e_ready = (m_clear == 0);
        @(posedge clk);
        @(negedge clk);
        check("inst", inst, e_inst);
        check("inst_valid", inst_valid, e_valid);
        check("fault_misalign", fault_misalign, e_mis);
        check("fault_range", fault_range, e_rng);
        check("ld_ack", ld_ack, e_ack);
        check("ready", ready, e_ready);
    endtask

    task automatic io(input logic req, input logic [31:0] fa, input logic st,
                      input logic we, input logic [31:0] la, input logic [31:0] ld);
        fetch_req = req; fetch_addr = fa; fetch_stall = st;
        ld_we = we; ld_addr = la; ld_data = ld;
        step();
    endtask

    task automatic run_clear(input string tag);
        int n;
        n = 0;
        rst = 1'b0;
        while (!ready && n < 400) begin
            step();
            n++;
        end
        check(tag, n, 256);
    endtask

    logic [31:0] acc;

    initial begin
        rst = 1'b1;
        io(0, 0, 0, 0, 0, 0);
        io(1, 0, 0, 1, 0, 32'hFFFF_FFFF);
        run_clear("clear_len");

        io(1, 32'h3FC, 0, 0, 0, 0);
        check("fetch_3fc_inst", inst, 32'h0);
        check("fetch_3fc_valid", inst_valid, 1);

        io(0, 0, 0, 1, 32'h000, 32'h8020_000A);
        check("load0_ack", ld_ack, 1);
        io(1, 32'h000, 0, 0, 0, 0);
        check("fetch0_inst", inst, 32'h8020_000A);
        check("fetch0_cell0", inst[7:0], 8'h0A);

        io(1, 32'h002, 0, 0, 0, 0);
        check("mis_flag", fault_misalign, 1);
        check("mis_inst", inst, 0);
        io(1, 32'h400, 0, 0, 0, 0);
        check("rng_flag", fault_range, 1);
        io(0, 0, 0, 1, 32'h401, 32'hDEAD_BEEF);
        check("bad_load_ack", ld_ack, 0);
        io(1, 32'h000, 0, 0, 0, 0);
        check("mem_unchanged", inst, 32'h8020_000A);

        io(1, 32'h000, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) io(1, 32'h004, 1, 0, 0, 0);
        check("stall_hold", inst, 32'h8020_000A);
        io(0, 0, 0, 0, 0, 0);
        check("stall_drop", inst_valid, 0);

        io(1, 32'h010, 0, 1, 32'h010, 32'h1234_5678);
        check("same_cycle_old", inst, 32'h0);
        io(1, 32'h010, 0, 0, 0, 0);
        check("same_cycle_new", inst, 32'h1234_5678);

        for (int c = 0; c < 1500; c++) begin
            logic [31:0] fa, la;
            int k;
            k = $urandom_range(0, 9);
            fa = (k < 7) ? {26'd0, 4'($urandom_range(0, 15)), 2'b00}
               : (k == 7) ? 32'($urandom_range(0, 1100))
               : (k == 8) ? 32'h3FC : $urandom;
            k = $urandom_range(0, 9);
            la = (k < 8) ? {26'd0, 4'($urandom_range(0, 15)), 2'b00} : 32'($urandom_range(0, 1100));
            rst = ($urandom_range(0, 699) == 0);
            io($urandom_range(0, 3) != 0, fa, $urandom_range(0, 4) == 0,
               $urandom_range(0, 2) == 0, la, $urandom);
        end
        rst = 1'b0;
        while (!ready) io(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 8; i++) io(0, 0, 0, 1, 32'(i * 4), 32'hA5A5_0000 + 32'(i));
        rst = 1'b1;
        io(1, 0, 0, 1, 0, 32'h1);
        run_clear("reclear_len");
        acc = '0;
        for (int i = 0; i < 256; i++) begin
            io(1, 32'(i * 4), 0, 0, 0, 0);
            acc = acc | inst;
        end
        check("all_zero_after_reset", acc, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, fetch/load address width in bits.
REQ-002 SHALL have parameter MEM_BYTES, default 1024, storage size in bytes; power of two, multiple of INST_BYTES.
REQ-003 SHALL have parameter CELL_WIDTH, default 8, bits per addressable cell.
REQ-004 SHALL have parameter INST_BYTES, default 4, cells per instruction word; power of two.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port fetch_req  input  1  fetch request.
REQ-008 SHALL have port fetch_addr  input  ADDR_WIDTH  cell (byte) address of fetch.
REQ-009 SHALL have port fetch_stall  input  1  downstream stall; freezes output stage.
REQ-010 SHALL have port inst  output  CELL_WIDTH*INST_BYTES  fetched instruction word.
REQ-011 SHALL have port inst_valid  output  1  inst/fault outputs valid.
REQ-012 SHALL have port fault_misalign  output  1  fetch address not word-aligned.
REQ-013 SHALL have port fault_range  output  1  fetch address beyond MEM_BYTES.
REQ-014 SHALL have port ld_we  input  1  program-load word write strobe.
REQ-015 SHALL have port ld_addr  input  ADDR_WIDTH  cell address of load word.
REQ-016 SHALL have port ld_data  input  CELL_WIDTH*INST_BYTES  load word.
REQ-017 SHALL have port ld_ack  output  1  load write accepted (one-cycle pulse).
REQ-018 SHALL have port ready  output  1  block out of CLEAR, accepting fetch/load.

Function
REQ-019 SHALL store MEM_BYTES cells of CELL_WIDTH bits; word at address A SHALL be little-endian: cell A in inst[CELL_WIDTH-1:0], cell A+INST_BYTES-1 in the MSBs.
REQ-020 SHALL implement FSM states CLEAR and RUN; rst forces CLEAR with word counter = 0.
REQ-021 In CLEAR, SHALL write zero to one word per cycle (counter 0..MEM_BYTES/INST_BYTES-1), then enter RUN the cycle after the last word; ready = 1 only in RUN.
REQ-022 In CLEAR, fetch_req and ld_we SHALL be ignored; inst_valid, ld_ack SHALL stay 0.
REQ-023 In RUN with fetch_stall = 0, fetch_req = 1 SHALL produce inst_valid = 1 with results on the next cycle (latency 1); fetch_req = 0 SHALL produce inst_valid = 0 next cycle.
REQ-024 With fetch_stall = 1, inst, inst_valid and fault outputs SHALL hold their values; fetch_req that cycle SHALL be dropped (requester re-presents).
REQ-025 fault_misalign SHALL be 1 when fetch_addr[log2(INST_BYTES)-1:0] != 0; fault_range SHALL be 1 when fetch_addr >= MEM_BYTES; both may be set together.
REQ-026 On any fault, inst SHALL be 0 and inst_valid SHALL still be 1; no memory wrap-around SHALL occur.
REQ-027 In RUN, ld_we = 1 with aligned in-range ld_addr SHALL write all INST_BYTES cells and pulse ld_ack next cycle; misaligned or out-of-range ld_addr SHALL be discarded with ld_ack = 0.
REQ-028 Fetch and load to the same word in the same cycle SHALL return the old (pre-write) data; the new data SHALL be visible to fetches issued from the next cycle.
REQ-029 Loads SHALL be independent of fetch_stall.

Reset
REQ-030 rst SHALL set inst = 0, inst_valid = 0, fault_misalign = 0, fault_range = 0, ld_ack = 0, ready = 0, state CLEAR, counter 0.
REQ-031 rst asserted mid-CLEAR or mid-RUN SHALL restart CLEAR from word 0; in-flight fetch results and load acks SHALL be discarded.

Verification
REQ-032 Defaults; release rst -> ready = 0 for 256 cycles, ready = 1 on cycle 257; fetch 0x3FC -> inst = 0x00000000, valid.
REQ-033 Load 0x8020000A at 0x000, fetch 0x000 -> next cycle inst = 0x8020000A, inst_valid = 1, faults 0; cell 0 = 0x0A.
REQ-034 Fetch 0x002 -> fault_misalign = 1, inst = 0; fetch 0x400 -> fault_range = 1, inst = 0; load to 0x401 -> ld_ack = 0, memory unchanged.
REQ-035 Fetch 0x000 then fetch_stall = 1 for 3 cycles with fetch 0x004 presented -> outputs hold 0x000 result; 0x004 not returned.
REQ-036 Same-cycle load 0x12345678 and fetch at 0x010 holding 0 -> inst = 0; refetch -> 0x12345678.
REQ-037 rst pulse during RUN after loads -> 256-cycle CLEAR repeats; all words read 0 afterward.
